// File: rtl/edl_pkg.sv
// Shared types and constants for the clocked error-detecting-latch token controller.
package edl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_DELAY,
        S_SAMPLE,
        S_RECOVER,
        S_OUT
    } edl_state_t;

    localparam int unsigned EDL_BORROW = 0;
    localparam int unsigned EDL_REPLAY = 1;

    // Bits needed to hold values 0..v (at least one bit).
    function automatic int unsigned edl_bits(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/edl_window_cnt.sv
// Loadable down-counter timing the DELAY, SAMPLE and RECOVER windows.
module edl_window_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/edl_token_ctrl_sync.sv
// Clocked token controller for a timing-resilient pipeline stage: capture, delay,
// error-sample window, then borrow (stretch) or replay on error, with error statistics.
module edl_token_ctrl_sync
    import edl_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned DELAY_B     = 3,
    parameter int unsigned DELAY_E     = 2,
    parameter int unsigned MODE        = 0,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l_req,
    output logic             l_ack,
    output logic             r_req,
    input  logic             r_ack,
    output logic             latch_en,
    output logic             sample,
    input  logic [LANES-1:0] err,
    output logic             err_any,
    output logic             recover,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fatal,
    output logic             busy
);

    // Counter reload values are window length minus one: done fires on the last cycle.
    localparam int unsigned DLY_LD = (DELAY_B > 0) ? DELAY_B - 1 : 0;
    localparam int unsigned SMP_LD = DELAY_E - 1;
    localparam int unsigned REC_LD = RECOVER_CYC - 1;
    localparam int unsigned MAX_A  = (DLY_LD > SMP_LD) ? DLY_LD : SMP_LD;
    localparam int unsigned MAX_LD = (MAX_A > REC_LD) ? MAX_A : REC_LD;
    localparam int unsigned CW     = edl_bits(MAX_LD);
    localparam int unsigned RW     = edl_bits(MAX_RETRY);

    edl_state_t       state_q, state_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             err_seen_q, err_seen_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fatal_q, fatal_d;
    logic             err_any_q, err_any_d;
    logic             latch_en_q, sample_q, recover_q, r_req_q, busy_q;

    logic             cnt_load;
    logic [CW-1:0]    cnt_val;
    logic             cnt_done_c;
    logic             err_hit_c;

    edl_window_cnt #(.W(CW)) u_win (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done_c   (cnt_done_c)
    );

    assign err_hit_c = err_seen_q | (|err);

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        err_seen_d = err_seen_q;
        err_cnt_d  = err_cnt_q;
        fatal_d    = fatal_q;
        err_any_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;

        case (state_q)
            S_IDLE: begin
                if (l_req) begin
                    state_d = S_CAPTURE;
                    retry_d = '0;
                end
            end
            S_CAPTURE: begin
                cnt_load = 1'b1;
                if (DELAY_B == 0) begin
                    state_d = S_SAMPLE;
                    cnt_val = CW'(SMP_LD);
                end else begin
                    state_d = S_DELAY;
                    cnt_val = CW'(DLY_LD);
                end
            end
            S_DELAY: begin
                if (cnt_done_c) begin
                    state_d  = S_SAMPLE;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(SMP_LD);
                end
            end
            S_SAMPLE: begin
                err_seen_d = err_hit_c;
                if (cnt_done_c) begin
                    if (err_hit_c) begin
                        err_any_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (MODE == EDL_BORROW) begin
                            state_d  = S_RECOVER;
                            cnt_load = 1'b1;
                            cnt_val  = CW'(REC_LD);
                        end else if (MODE == EDL_REPLAY && retry_q < RW'(MAX_RETRY)) begin
                            state_d = S_CAPTURE;
                            retry_d = retry_q + RW'(1);
                        end else begin
                            state_d = S_OUT;
                            fatal_d = 1'b1;
                        end
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_RECOVER: begin
                if (cnt_done_c) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (r_ack) begin
                    if (l_req) begin
                        state_d = S_CAPTURE;
                        retry_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_CAPTURE) begin
            err_seen_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            retry_q    <= '0;
            err_seen_q <= 1'b0;
            err_cnt_q  <= '0;
            fatal_q    <= 1'b0;
            err_any_q  <= 1'b0;
            latch_en_q <= 1'b0;
            sample_q   <= 1'b0;
            recover_q  <= 1'b0;
            r_req_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            err_seen_q <= err_seen_d;
            err_cnt_q  <= err_cnt_d;
            fatal_q    <= fatal_d;
            err_any_q  <= err_any_d;
            latch_en_q <= (state_d == S_CAPTURE);
            sample_q   <= (state_d == S_SAMPLE);
            recover_q  <= (state_d == S_RECOVER);
            r_req_q    <= (state_d == S_OUT);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign l_ack    = ~rst & ((state_q == S_IDLE) | ((state_q == S_OUT) & r_ack));
    assign r_req    = r_req_q;
    assign latch_en = latch_en_q;
    assign sample   = sample_q;
    assign recover  = recover_q;
    assign err_any  = err_any_q;
    assign err_cnt  = err_cnt_q;
    assign fatal    = fatal_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_edl_token_ctrl_sync.sv
// Bench for edl_token_ctrl_sync: borrow (defaults), replay with 2-bit counter, and DELAY_B=0 instances.
module tb_edl_token_ctrl_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       l_req    [3];
    logic       r_ack    [3];
    logic [3:0] err      [3];
    logic       l_ack    [3];
    logic       r_req    [3];
    logic       latch_en [3];
    logic       sample   [3];
    logic       err_any  [3];
    logic       recover  [3];
    logic       fatal    [3];
    logic       busy     [3];
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    typedef struct {
        int inst;
        int cyc;
        int cnt;
        bit fat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rise [3];
    logic prev [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    edl_token_ctrl_sync u0 (
        .clk(clk), .rst(rst), .l_req(l_req[0]), .l_ack(l_ack[0]), .r_req(r_req[0]),
        .r_ack(r_ack[0]), .latch_en(latch_en[0]), .sample(sample[0]), .err(err[0]),
        .err_any(err_any[0]), .recover(recover[0]), .err_cnt(cnt0), .fatal(fatal[0]),
        .busy(busy[0])
    );

    edl_token_ctrl_sync #(.MODE(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .l_req(l_req[1]), .l_ack(l_ack[1]), .r_req(r_req[1]),
        .r_ack(r_ack[1]), .latch_en(latch_en[1]), .sample(sample[1]), .err(err[1]),
        .err_any(err_any[1]), .recover(recover[1]), .err_cnt(cnt1), .fatal(fatal[1]),
        .busy(busy[1])
    );

    edl_token_ctrl_sync #(.DELAY_B(0)) u2 (
        .clk(clk), .rst(rst), .l_req(l_req[2]), .l_ack(l_ack[2]), .r_req(r_req[2]),
        .r_ack(r_ack[2]), .latch_en(latch_en[2]), .sample(sample[2]), .err(err[2]),
        .err_any(err_any[2]), .recover(recover[2]), .err_cnt(cnt2), .fatal(fatal[2]),
        .busy(busy[2])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each delivery pops the oldest expected token and checks it.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (r_req[i] && !prev[i]) rise[i] = cyc;
            if (r_req[i] && r_ack[i] && !rst) begin
                chk($sformatf("i%0d delivery expected", i), int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk($sformatf("i%0d delivery inst", i), i, mon_e.inst);
                    chk($sformatf("i%0d r_req rise cycle", i), rise[i], mon_e.cyc);
                    chk($sformatf("i%0d err_cnt at delivery", i), get_cnt(i), mon_e.cnt);
                    chk($sformatf("i%0d fatal at delivery", i), int'(fatal[i]), int'(mon_e.fat));
                end
            end
            prev[i] = r_req[i];
        end
    end

    // One token with r_ack high; masks give expected per-cycle outputs by offset k.
    task automatic token(input int i, input logic [31:0] err_m, input logic [3:0] ev,
                         input int ncyc, input logic [31:0] le_m, input logic [31:0] smp_m,
                         input logic [31:0] rec_m, input logic [31:0] ea_m,
                         input int req_k, input int cnt, input bit fat);
        int t0;
        t0 = cyc;
        chk($sformatf("i%0d l_ack idle", i), int'(l_ack[i]), 1);
        l_req[i] = 1'b1;
        sb.push_back('{i, t0 + req_k, cnt, fat});
        for (int k = 1; k <= ncyc; k++) begin
            step();
            l_req[i] = 1'b0;
            err[i]   = err_m[k] ? ev : 4'b0;
            chk($sformatf("i%0d k%0d latch_en", i, k), int'(latch_en[i]), int'(le_m[k]));
            chk($sformatf("i%0d k%0d sample", i, k), int'(sample[i]), int'(smp_m[k]));
            chk($sformatf("i%0d k%0d recover", i, k), int'(recover[i]), int'(rec_m[k]));
            chk($sformatf("i%0d k%0d err_any", i, k), int'(err_any[i]), int'(ea_m[k]));
            chk($sformatf("i%0d k%0d busy", i, k), int'(busy[i]), int'(k <= req_k));
        end
        err[i] = 4'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            l_req[i] = 1'b0;
            r_ack[i] = 1'b1;
            err[i]   = 4'b0;
            prev[i]  = 1'b0;
            rise[i]  = -1;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d reset r_req", i), int'(r_req[i]), 0);
            chk($sformatf("i%0d reset l_ack", i), int'(l_ack[i]), 0);
            chk($sformatf("i%0d reset busy", i), int'(busy[i]), 0);
            chk($sformatf("i%0d reset err_cnt", i), get_cnt(i), 0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("i%0d l_ack after release", i), int'(l_ack[i]), 1);
        step();

        // Borrow instance: clean, borrow on lane 2, error during DELAY only.
        token(0, 32'h0, 4'b0000, 8, 32'h2, 32'h60, 32'h0, 32'h0, 7, 0, 1'b0);
        token(0, 32'h20, 4'b0100, 10, 32'h2, 32'h60, 32'h180, 32'h80, 9, 1, 1'b0);
        token(0, 32'h1C, 4'b1111, 8, 32'h2, 32'h60, 32'h0, 32'h0, 7, 1, 1'b0);

        // Backpressure, then simultaneous downstream and upstream transfer.
        t0 = cyc;
        chk("bp l_ack idle", int'(l_ack[0]), 1);
        l_req[0] = 1'b1;
        r_ack[0] = 1'b0;
        sb.push_back('{0, t0 + 7, 1, 1'b0});
        for (int k = 1; k <= 11; k++) begin
            step();
            l_req[0] = (k >= 7);
            if (k >= 7) begin
                chk($sformatf("bp k%0d r_req held", k), int'(r_req[0]), 1);
                chk($sformatf("bp k%0d l_ack low", k), int'(l_ack[0]), 0);
            end
        end
        step();
        r_ack[0] = 1'b1;
        #1;
        chk("bp l_ack follows r_ack", int'(l_ack[0]), 1);
        sb.push_back('{0, t0 + 19, 1, 1'b0});
        step();
        l_req[0] = 1'b0;
        chk("bp latch_en after both", int'(latch_en[0]), 1);
        chk("bp r_req dropped after ack", int'(r_req[0]), 0);
        for (int k = 14; k <= 20; k++) step();

        // Replay instance: one replay, then errors on all four attempts (fatal, 2-bit saturation).
        token(1, 32'h20, 4'b0001, 14, 32'h82, 32'h1860, 32'h0, 32'h80, 13, 1, 1'b0);
        token(1, 32'h00820820, 4'b1000, 26, 32'h00082082, 32'h01861860, 32'h0,
              32'h02082080, 25, 3, 1'b1);

        // DELAY_B=0 instance: DELAY skipped.
        token(2, 32'h0, 4'b0000, 5, 32'h2, 32'hC, 32'h0, 32'h0, 4, 0, 1'b0);

        // Reset with u1 in SAMPLE and u2 holding r_req under backpressure.
        l_req[1] = 1'b1;
        l_req[2] = 1'b1;
        r_ack[2] = 1'b0;
        step();
        l_req[1] = 1'b0;
        l_req[2] = 1'b0;
        for (int k = 2; k <= 6; k++) step();
        chk("pre-rst u1 sample", int'(sample[1]), 1);
        chk("pre-rst u1 fatal", int'(fatal[1]), 1);
        chk("pre-rst u1 err_cnt", get_cnt(1), 3);
        chk("pre-rst u2 r_req", int'(r_req[2]), 1);
        rst = 1'b1;
        #1;
        chk("rst u2 r_req", int'(r_req[2]), 0);
        chk("rst u1 sample", int'(sample[1]), 0);
        chk("rst u1 err_cnt", get_cnt(1), 0);
        chk("rst u1 fatal", int'(fatal[1]), 0);
        chk("rst u1 l_ack", int'(l_ack[1]), 0);
        chk("rst u0 err_cnt", get_cnt(0), 0);
        step();
        rst = 1'b0;
        r_ack[2] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d l_ack after mid-token reset", i), int'(l_ack[i]), 1);
            chk($sformatf("i%0d busy after mid-token reset", i), int'(busy[i]), 0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("u2 token dropped k%0d", k), int'(r_req[2]), 0);
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
